// File: rtl/fsm_ti_pkg.sv
// Shared types and helpers for the trigger-instrumented FSM benchmarks.
// Latency: none (declarations and pure functions only).
// Backpressure: none.
package fsm_ti_pkg;

  typedef enum logic [2:0] {
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } state_t;

  localparam int MODE_FREEZE  = 0;
  localparam int MODE_CORRUPT = 1;
  localparam int MODE_DIVERT  = 2;

  // One-hot output pattern for a state: S1 -> bit 0 ... S6 -> bit 5.
  // An illegal encoding shifts past the 6-bit result and yields zero.
  function automatic logic [5:0] pat(input state_t s);
    logic [2:0] idx;
    idx = 3'(s) - 3'd1;
    pat = 6'b000001 << idx;
  endfunction

endpackage

// File: rtl/fsm_ti_param_if.sv
// Bundles the control inputs and observable outputs of the benchmark FSM.
// Latency: none (wires only).
// Backpressure: none.
interface fsm_ti_param_if #(
  parameter int NY = 25
);
  logic [4:0]    x;
  logic [NY-1:0] y;
  logic          trig;
  logic [2:0]    state_o;

  modport master (output x, input y, input trig, input state_o);
  modport slave  (input x, output y, output trig, output state_o);
endinterface

// File: rtl/ti_trigger.sv
// Counts qualifying events, saturating at THRESH, and raises a sticky arm flag.
// Latency: trig registers on the negedge carrying the THRESH-th hit; arm is combinational.
// Backpressure: none; every hit presented on an edge is counted until saturation.
module ti_trigger #(
  parameter int CNT_W  = 3,
  parameter int THRESH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  output logic trig,
  output logic arm
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

  logic [CNT_W-1:0] cnt;

  // arm is high on the edge where this hit brings the count up to the threshold,
  // so a consumer can act on the arming edge itself.
  always_comb begin
    arm = 1'b0;
    if (hit && (cnt == (THR - 1'b1))) begin
      arm = 1'b1;
    end
  end

  // Saturating counter plus sticky trigger; both clear only on reset.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      trig <= 1'b0;
    end else begin
      if (hit && (cnt != THR)) begin
        cnt <= cnt + 1'b1;
      end
      if (arm) begin
        trig <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_ti_param.sv
// Six-state controller with a one-hot output bus and a parametrised trojan payload.
// Latency: state and y update one negedge after x is sampled; trig on the counted entry edge.
// Backpressure: none; a transition is taken on every negedge.
module fsm_ti_param
  import fsm_ti_pkg::*;
#(
  parameter int            NY         = 25,
  parameter int            CNT_W      = 3,
  parameter int            THRESH     = 5,
  parameter int            TRIG_STATE = 6,
  parameter int            MODE       = 0,
  parameter logic [NY-1:0] MASK       = '1
) (
  input  logic            clk,
  input  logic            rst,
  fsm_ti_param_if.slave   bus
);

  localparam state_t TS = state_t'(3'(TRIG_STATE));

  state_t        state;
  state_t        nxt_nom;
  state_t        nxt;
  logic [NY-1:0] y_r;
  logic          hit;
  logic          trig;
  logic          arm;
  logic          trig_now;

  // Nominal transition function; anything unrecognised recovers to S1.
  always_comb begin
    nxt_nom = S1;
    case (state)
      S1: nxt_nom = S2;
      S2: begin
        if (!bus.x[3])     nxt_nom = S5;
        else if (bus.x[4]) nxt_nom = S3;
        else               nxt_nom = S4;
      end
      S3: nxt_nom = bus.x[0] ? S6 : S2;
      S4: nxt_nom = bus.x[1] ? S6 : S5;
      S5: nxt_nom = bus.x[3] ? S1 : S4;
      S6: nxt_nom = S2;
      default: nxt_nom = S1;
    endcase
  end

  // Payload steering uses the registered trig, so the arming edge itself
  // still follows the nominal path and the override starts one edge later.
  always_comb begin
    nxt = nxt_nom;
    if (trig) begin
      if (MODE == MODE_FREEZE) begin
        if (state == TS) nxt = TS;
      end else if (MODE == MODE_DIVERT) begin
        nxt = S1;
      end
    end
  end

  assign hit      = (nxt == TS);
  assign trig_now = trig | arm;

  ti_trigger #(
    .CNT_W  (CNT_W),
    .THRESH (THRESH)
  ) u_trig (
    .clk  (clk),
    .rst  (rst),
    .hit  (hit),
    .trig (trig),
    .arm  (arm)
  );

  // State and output register; corruption looks at trig_now so the arming
  // edge's output is already masked.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= S1;
      y_r   <= '0;
    end else begin
      state <= nxt;
      if ((MODE == MODE_CORRUPT) && trig_now) begin
        y_r <= NY'(pat(nxt)) ^ MASK;
      end else begin
        y_r <= NY'(pat(nxt));
      end
    end
  end

  assign bus.y       = y_r;
  assign bus.trig    = trig;
  assign bus.state_o = 3'(state);

endmodule

// File: doc/fsm_ti_param.md
Name: fsm_ti_param

Overview:
- Parametrised trigger-instrumented FSM benchmark. It is the next generation of the fixed single-trojan controller benchmarks.
- A 6-state Mealy-input controller drives a one-hot output bus.
- A configurable trigger unit counts entries into a selectable trigger state. Once a threshold is reached it activates one of three payload modes.
- Used as a golden-plus-infected test article for the detection flow. The trig and state_o ports exist for bench observability only.

Parameters:
- NY, 25, output bus width; must be >= 6.
- CNT_W, 3, trigger counter width.
- THRESH, 5, entry count that arms the payload; 1 <= THRESH < 2**CNT_W.
- TRIG_STATE, 6, state (1..6) whose entries are counted.
- MODE, 0, payload: 0 = freeze in TRIG_STATE, 1 = output corruption, 2 = divert to S1.
- MASK, all-ones (NY bits), XOR mask applied in MODE 1.

Ports:
- clk  in  1  clock; all state updates on negedge clk.
- rst  in  1  asynchronous, active-low reset.
- x  in  5  control inputs x[4:0].
- y  out  NY  registered output pattern.
- trig  out  1  payload armed (sticky).
- state_o  out  3  present state encoding, 1..6.

Behaviour:
- Reset: rst low forces asynchronously, with no clock needed: state=S1, y=0, cnt=0, trig=0. Reset asserted mid-operation, including after arming, clears everything.
- Encodings: S1..S6 = 3'd1..3'd6. Any illegal encoding goes to S1 on the next edge.
- Nominal next-state function, evaluated each negedge clk:
  - S1 -> S2 unconditionally.
  - S2: x[3]&x[4] -> S3; x[3]&~x[4] -> S4; ~x[3] -> S5.
  - S3: x[0] -> S6; else S2.
  - S4: x[1] -> S6; else S5.
  - S5: x[3] -> S1; else S4.
  - S6 -> S2 unconditionally.
- Output: y updates on the same edge as the state.
  - y = PAT(next) = 1 << (next-1), i.e. one-hot bit 0..5.
  - In MODE 1 with trig=1 (or trig becoming 1 on that edge): y = PAT(next) ^ MASK.
- Counter:
  - cnt increments on each edge where next state == TRIG_STATE. This includes self-loops created by the freeze payload.
  - cnt saturates at THRESH and never wraps.
  - trig is set on the edge where cnt becomes THRESH; it is sticky until reset.
- Payload, effective from the arming edge onward:
  - MODE 0: if present state == TRIG_STATE, next = TRIG_STATE. The machine is locked there and y holds PAT(TRIG_STATE).
  - MODE 1: state sequence is unchanged; outputs are XOR-corrupted from the arming edge.
  - MODE 2: every transition after the arming edge targets S1. The machine stays in S1 and y = PAT(S1).
- Simultaneous events:
  - The arming edge itself uses the nominal transition (which entered TRIG_STATE).
  - Payload overrides apply from the following edge.
  - MODE 1 is the exception: y on the arming edge is already corrupted.
- Latency:
  - State and y are one negedge after inputs are sampled.
  - trig is registered on the same edge as the counted entry.
- Width rules:
  - cnt is CNT_W bits with an unsigned compare against THRESH.
  - MASK is truncated or zero-extended to NY.

Decomposition:
- Shared package fsm_ti_pkg holds:
  - state typedef/constants S1..S6;
  - MODE_FREEZE / MODE_CORRUPT / MODE_DIVERT constants;
  - a PAT function.
- Sub-module ti_trigger holds the counter, saturation and sticky arm. Inputs: clk, rst, hit. Output: trig. It is parametrised by CNT_W and THRESH, so the same trigger is reused across benchmark FSMs.
- The payload muxing stays in the top module.

Test Plan:
- Reset/idle: rst=0 then release with x=0 -> state_o=1, y=0.
  - Edge 1: state 2, y=6'b000010.
  - Edge 2: state 5, y=6'b010000.
  - Then S5<->S4 alternating; trig stays 0 indefinitely.
- MODE 0, x=5'b11001: cycle S2,S3,S6 with S6 entries at edges 3,6,9,12,15.
  - trig=1 at edge 15.
  - From edge 16 on: state_o=6, y=6'b100000 forever.
- MODE 1, same stimulus: trig=1 at edge 15, y=~(1<<5) (NY bits).
  - Edge 16: state 2, y=~6'b000010 in low bits, upper bits 1.
  - The sequence keeps cycling.
- MODE 2, same stimulus: edge 15 state 6, trig=1.
  - Edge 16 onward: state_o=1, y=6'b000001; x changes have no effect.
- Reset mid-operation: in MODE 0, after arming, pulse rst low between edges.
  - Immediately (asynchronously): state=1, y=0, trig=0.
  - Counting restarts; trig re-arms only after 5 further entries.
- Parameter sweep: THRESH=1, TRIG_STATE=4, x=5'b00010.
  - Path S1, S2, S5, S4 gives the first S4 entry at edge 3, so trig=1 at edge 3.
  - Also CNT_W=3, THRESH=7: check cnt saturates at 7 with no wrap after 20 entries.
